// File: rtl/sync_deserializer.sv
// Serial-to-parallel frame receiver: hunts for a PRE_W-bit preamble, then collects DATA_W payload bits MSB first.
// Optional trailing even-parity bit is enabled by defining DESER_PARITY_EN.
module sync_deserializer #(
  parameter int                DATA_W   = 32,
  parameter int                PRE_W    = 2,
  parameter logic [PRE_W-1:0]  PREAMBLE = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              data_in,
  input  logic              sync_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int CNT_MAX = (DATA_W > PRE_W) ? DATA_W : PRE_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRE_FULL  = CNT_W'(PRE_W);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1, PAR = 2'd2} state_e;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1} state_e;
`endif

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
`ifdef DESER_PARITY_EN
  logic               frame_err_q, frame_err_d;
`endif

  logic [PRE_W-1:0]   pre_next;
  logic [DATA_W-1:0]  word_next;
  logic               commit;
  logic [DATA_W-1:0]  commit_word;

  // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
`ifdef DESER_PARITY_EN
    frame_err_d  = 1'b0;
`endif
    pre_next    = PRE_W'({pre_q, data_in});
    word_next   = DATA_W'({shift_q, data_in});
    commit      = 1'b0;
    commit_word = word_next;

    if (sync_clr) begin
      // Abort wins over anything the current bit would have completed.
      state_d = HUNT;
      pre_d   = '0;
      cnt_d   = '0;
      shift_d = '0;
    end else if (bit_en) begin
      case (state_q)
        HUNT: begin
          pre_d = pre_next;
          if (cnt_q < PRE_FULL) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= PRE_LAST && pre_next == PREAMBLE) begin
            state_d = DATA;
            cnt_d   = '0;
            pre_d   = '0;
          end
        end
        DATA: begin
          shift_d = word_next;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
`ifdef DESER_PARITY_EN
            state_d = PAR;
`else
            state_d = HUNT;
            pre_d   = '0;
            commit  = 1'b1;
`endif
          end
        end
`ifdef DESER_PARITY_EN
        PAR: begin
          state_d = HUNT;
          cnt_d   = '0;
          pre_d   = '0;
          if (^{shift_q, data_in}) begin
            frame_err_d = 1'b1;
          end else begin
            commit      = 1'b1;
            commit_word = shift_q;
          end
        end
`endif
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
          pre_d   = '0;
        end
      endcase
    end

    if (commit) begin
      data_out_d   = commit_word;
      data_valid_d = 1'b1;
      if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop, the payload shift register included, takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      pre_q        <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef DESER_PARITY_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef DESER_PARITY_EN
      frame_err_q  <= frame_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != HUNT);
`ifdef DESER_PARITY_EN
  assign frame_err  = frame_err_q;
`else
  assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_deserializer.sv
// Bench for sync_deserializer: frame table, directed abort/reset sequences, then random bits against a queue-based model.
module tb_sync_deserializer;

  localparam int               DATA_W = 32;
  localparam int               PRE_W  = 2;
  localparam logic [PRE_W-1:0] TB_PRE = 2'b11;
`ifdef DESER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bit_en = 1'b0;
  logic              data_in = 1'b0;
  logic              sync_clr = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  sync_deserializer #(.DATA_W(DATA_W), .PRE_W(PRE_W), .PREAMBLE(TB_PRE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .data_in    (data_in),
    .sync_clr   (sync_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bits kept in queues, frame judged once enough bits are collected.
  bit                hunt_q[$];
  bit                pay_q[$];
  bit                m_collect;
  logic [DATA_W-1:0] m_out;
  logic [15:0]       m_cnt;
  bit                m_valid, m_err;

  task automatic model_reset();
    hunt_q.delete();
    pay_q.delete();
    m_collect = 0;
    m_out = '0;
    m_cnt = '0;
    m_valid = 0;
    m_err = 0;
  endtask

  task automatic model_step(input bit en, input bit din, input bit clr);
    bit match;
    int ones;
    logic [DATA_W-1:0] word;
    m_valid = 0;
    m_err   = 0;
    if (clr) begin
      m_collect = 0;
      hunt_q.delete();
      pay_q.delete();
      return;
    end
    if (!en) return;
    if (!m_collect) begin
      hunt_q.push_back(din);
      if (hunt_q.size() > PRE_W) void'(hunt_q.pop_front());
      if (hunt_q.size() == PRE_W) begin
        match = 1;
        for (int k = 0; k < PRE_W; k++)
          if (hunt_q[k] != TB_PRE[PRE_W-1-k]) match = 0;
        if (match) begin
          m_collect = 1;
          pay_q.delete();
        end
      end
    end else begin
      pay_q.push_back(din);
      if (pay_q.size() == DATA_W + PAR_BITS) begin
        word = '0;
        for (int k = 0; k < DATA_W; k++) word = {word[DATA_W-2:0], pay_q[k]};
        ones = 0;
        foreach (pay_q[k]) ones += int'(pay_q[k]);
        if (PAR_BITS == 0 || (ones % 2) == 0) begin
          m_out   = word;
          m_valid = 1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          m_err = 1;
        end
        m_collect = 0;
        hunt_q.delete();
        pay_q.delete();
      end
    end
  endtask

  // One clock: drive at the falling edge, model on the rising edge, sample 1 ns later.
  task automatic step(input bit en, input bit din, input bit clr);
    bit_en   = en;
    data_in  = din;
    sync_clr = clr;
    @(posedge clk);
    model_step(en, din, clr);
    #1;
    check("data_out", 64'(data_out), 64'(m_out));
    check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    check("valid/err/busy", 64'({data_valid, frame_err, busy}), 64'({m_valid, m_err, m_collect}));
    @(negedge clk);
  endtask

  // Sends lead bits, payload MSB first, then the parity bit when enabled.
  task automatic send_frame(input logic [7:0] lead, input int lead_n, input logic [31:0] word,
                            input bit bad_par, input int gap, input bit clr_last);
    bit bits[$];
    for (int i = lead_n - 1; i >= 0; i--) bits.push_back(lead[i]);
    for (int i = DATA_W - 1; i >= 0; i--) bits.push_back(word[i]);
    if (PAR_BITS != 0) bits.push_back((^word) ^ bad_par);
    foreach (bits[i]) begin
      repeat (gap) step(1'b0, 1'($urandom), 1'b0);
      step(1'b1, bits[i], clr_last && (i == bits.size() - 1));
    end
  endtask

  typedef struct {
    logic [7:0]  lead;
    int          lead_n;
    logic [31:0] word;
    bit          bad_par;
    int          gap;
    logic [31:0] exp_out;
    logic [15:0] exp_cnt;
    bit          exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h03, 2, 32'hA5A5_0F0F, 1'b0, 0, 32'hA5A5_0F0F, 16'd1, 1'b0};
    tbl[1] = '{8'h0B, 5, 32'h8000_0001, 1'b0, 0, 32'h8000_0001, 16'd2, 1'b0};
    tbl[2] = '{8'h03, 2, 32'hA5A5_0F0F, 1'b0, 2, 32'hA5A5_0F0F, 16'd3, 1'b0};
    tbl[3] = '{8'h03, 2, 32'h0000_0001, 1'b1, 0, 32'hA5A5_0F0F, 16'd3, 1'b1};
    tbl[4] = '{8'h03, 2, 32'h0000_0001, 1'b0, 0, 32'h0000_0001, 16'd4, 1'b0};
    tbl[5] = '{8'h0B, 4, 32'h0F0F_A5A5, 1'b0, 1, 32'h0F0F_A5A5, 16'd5, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    check("reset outputs", 64'({data_out, data_valid, busy, frame_err, frame_cnt}), 64'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      if (tbl[i].bad_par && PAR_BITS == 0) continue;
      send_frame(tbl[i].lead, tbl[i].lead_n, tbl[i].word, tbl[i].bad_par, tbl[i].gap, 1'b0);
      check($sformatf("vec%0d valid after last bit", i), 64'(data_valid), 64'(!tbl[i].exp_err));
      check($sformatf("vec%0d frame_err", i), 64'(frame_err), 64'(tbl[i].exp_err));
      step(1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d pulse width", i), 64'({data_valid, frame_err}), 64'd0);
      check($sformatf("vec%0d data_out", i), 64'(data_out), 64'(tbl[i].exp_out));
      check($sformatf("vec%0d frame_cnt", i), 64'(frame_cnt), 64'(tbl[i].exp_cnt));
    end

    // Abort after 10 payload bits, then a clean frame.
    send_frame(8'h00, 0, 32'h0000_0000, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("sync_clr busy/pulses", 64'({data_valid, frame_err, busy}), 64'd0);
    send_frame(8'h03, 2, 32'h1234_5678, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("after abort data_out", 64'(data_out), 64'h1234_5678);
    check("after abort frame_cnt", 64'(frame_cnt), 64'd6);

    // sync_clr on the final bit beats the commit.
    send_frame(8'h03, 2, 32'hCAFE_F00D, 1'b0, 0, 1'b1);
    check("clr vs commit pulses", 64'({data_valid, frame_err, busy}), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    check("clr vs commit data_out", 64'(data_out), 64'h1234_5678);

    // Asynchronous reset after 20 payload bits.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid-frame reset outputs", 64'({data_out, data_valid, busy, frame_err, frame_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h03, 2, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("post-reset data_out", 64'(data_out), 64'hDEAD_BEEF);
    check("post-reset frame_cnt", 64'(frame_cnt), 64'd1);

    // Random bit stream with sparse strobes and rare aborts.
    for (int i = 0; i < 4000; i++)
      step(($urandom % 4) != 0, 1'($urandom), ($urandom % 300) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_deserializer.md
SYNC_DESERIALIZER -- requirements
Module: sync_deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload bits per frame (legal 2..64).
REQ-002 SHALL have parameter PRE_W, default 2, preamble length in bits (legal 1..8).
REQ-003 SHALL have parameter PREAMBLE, default 2'b11, preamble pattern, PRE_W bits, first-received bit in MSB.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port bit_en  input  1  sample strobe; data_in consumed only in cycles with bit_en=1.
REQ-007 SHALL have port data_in  input  1  serial data, MSB first.
REQ-008 SHALL have port sync_clr  input  1  synchronous abort of the current frame, return to HUNT.
REQ-009 SHALL have port data_out  output  DATA_W  last good received word, held until replaced.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse on data_out update.
REQ-011 SHALL have port busy  output  1  high in DATA or PAR state.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on parity failure.
REQ-013 SHALL have port frame_cnt  output  16  count of good frames, saturating at 16'hFFFF.

Function
REQ-014 SHALL implement FSM states HUNT, DATA, PAR; all state changes occur only in bit_en cycles, except for sync_clr.
REQ-015 HUNT SHALL shift bits into a PRE_W preamble register and count them, saturating at PRE_W; it SHALL go to DATA when at least PRE_W bits have been received since entering HUNT and the register including the current bit equals PREAMBLE.
REQ-016 A match SHALL reset the bit counter to 0; overlapping preamble candidates SHALL be recognised (sliding match).
REQ-017 DATA SHALL shift each bit_en bit into the LSB of an internal DATA_W shift register and increment the counter.
REQ-018 On the bit_en cycle with counter==DATA_W-1, the FSM SHALL go to PAR when DESER_PARITY_EN is defined, else to HUNT, committing the word.
REQ-019 PAR SHALL consume one bit; even parity (XOR of DATA_W bits and parity bit == 0) SHALL commit the word; odd parity SHALL pulse frame_err and leave data_out unchanged; either way the FSM SHALL go to HUNT.
REQ-020 Commit SHALL load data_out and pulse data_valid in the cycle after the final consumed bit (latency 1 clk), and SHALL increment frame_cnt unless it is at 16'hFFFF.
REQ-021 On entering HUNT, the preamble register and its bit count SHALL clear, so a new frame needs a full fresh preamble; bits of the ending frame never form a preamble.
REQ-022 When sync_clr=1, the FSM SHALL go to HUNT next cycle, discard the partial word, clear the counters and preamble register, and produce no data_valid or frame_err; sync_clr SHALL take priority over a simultaneous commit.
REQ-023 bit_en=0 cycles SHALL freeze all state, counters and shift registers.
REQ-024 data_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-025 With rst_n low, the FSM SHALL be in HUNT and data_out, data_valid, busy, frame_err, frame_cnt, counters, preamble register and shift register SHALL all be 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse outputs; after release, the block SHALL hunt for a new preamble.

Configuration
REQ-027 Macro DESER_PARITY_EN defined: the PAR state and the frame_err logic SHALL be present, and a frame SHALL be PRE_W+DATA_W+1 bits.
REQ-028 Macro DESER_PARITY_EN undefined: there SHALL be no PAR state, frame_err SHALL be tied 0, and a frame SHALL be PRE_W+DATA_W bits.

Verification (DATA_W=32, PRE_W=2, PREAMBLE=2'b11)
REQ-029 Send bit_en continuous, bits 1,1 then 32'hA5A5_0F0F MSB first (+ parity 0 if enabled) -> data_out=32'hA5A5_0F0F, data_valid 1 clk after the last bit, frame_cnt=1.
REQ-030 Parity enabled, send 32'h0000_0001 with parity 0 -> frame_err pulse, data_out keeps its previous value, frame_cnt unchanged.
REQ-031 Send bits 0,1,0,1,1 then the payload 32'h8000_0001 -> preamble found on the 5th bit, data_out=32'h8000_0001.
REQ-032 bit_en toggling 1-of-3 cycles during the frame of REQ-029 -> same data_out, with data_valid one clk after the last strobed bit.
REQ-033 Assert sync_clr after 10 payload bits, then send a full frame of 32'h1234_5678 -> no pulse for the aborted frame, data_out=32'h1234_5678.
REQ-034 Assert rst_n low after 20 payload bits, then release -> all outputs 0 and the next full frame is received correctly.
